// File: rtl/mat_bc_tx.sv
// mat_bc_tx: command-driven broadcast transmitter that feeds the first lane's chain register through a skid FIFO.
// Optional feature macro MAT_BC_TX_PARITY_EN adds bc_parity_o (XOR of bc_data_o, timed with it).
module mat_bc_tx #(
  parameter int unsigned NrLanes = 4,
  parameter int unsigned Depth   = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [15:0] cmd_len_i,
  input  logic        opnd_valid_i,
  output logic        opnd_ready_o,
  input  logic [63:0] opnd_data_i,
  output logic [63:0] bc_data_o,
  output logic        bc_data_valid_o,
  input  logic        bc_data_ready_i,
  input  logic        bc_data_invalidate_i,
`ifdef MAT_BC_TX_PARITY_EN
  output logic        bc_parity_o,
`endif
  output logic        done_o,
  output logic        busy_o
);

  localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [AW:0] FullCnt = (AW + 1)'(Depth);

  if (NrLanes == 0 || Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_cfg_check
    $error("mat_bc_tx: NrLanes must be >= 1 and Depth a power of two >= 2");
  end

  typedef enum logic {
    StIdle,
    StStream
  } state_e;

  state_e r_state;
  state_e w_next_state;

  logic [15:0]   r_len;
  logic [15:0]   r_in_cnt;
  logic [15:0]   r_out_cnt;
  logic [63:0]   r_mem [Depth];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_empty;
  logic w_full;
  logic w_len_reached;
  logic w_cmd_hs;
  logic w_push;
  logic w_pop;

  // Invalidate masks every handshake, so nothing moves in an aborted cycle.
  assign w_empty       = (r_count == '0);
  assign w_full        = (r_count == FullCnt);
  assign w_len_reached = (r_out_cnt == r_len);
  assign w_cmd_hs      = cmd_valid_i & cmd_ready_o & ~bc_data_invalidate_i;
  assign w_push        = opnd_valid_i & opnd_ready_o & ~bc_data_invalidate_i;
  assign w_pop         = bc_data_valid_o & bc_data_ready_i & ~bc_data_invalidate_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (bc_data_invalidate_i) begin
      w_next_state = StIdle;
    end else begin
      case (r_state)
        StIdle:   if (cmd_valid_i) w_next_state = StStream;
        StStream: if (w_len_reached) w_next_state = StIdle;
        default:  w_next_state = StIdle;
      endcase
    end
  end

  always_comb begin
    cmd_ready_o  = (r_state == StIdle);
    busy_o       = (r_state != StIdle);
    opnd_ready_o = (r_state == StStream) && !w_full && (r_in_cnt < r_len);
    done_o       = (r_state == StStream) && w_len_reached && !bc_data_invalidate_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_len     <= '0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else if (bc_data_invalidate_i) begin
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else if (w_cmd_hs) begin
      r_len     <= cmd_len_i;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else begin
      if (w_push) r_in_cnt <= r_in_cnt + 16'd1;
      if (w_pop) r_out_cnt <= r_out_cnt + 16'd1;
    end
  end

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bc_data_invalidate_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= opnd_data_i;
  end

  assign bc_data_valid_o = ~w_empty;
  assign bc_data_o       = bc_data_valid_o ? r_mem[r_rd_ptr] : '0;

`ifdef MAT_BC_TX_PARITY_EN
  assign bc_parity_o = ^bc_data_o;
`endif

endmodule

// File: tb/tb_mat_bc_tx.sv
// tb_mat_bc_tx: directed and random stimulus for mat_bc_tx, checked against a queue-based transaction model.
// Also checks bc_parity_o when MAT_BC_TX_PARITY_EN is defined.
module tb_mat_bc_tx;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_len;
  logic        opnd_valid;
  logic        opnd_ready;
  logic [63:0] opnd_data;
  logic [63:0] bc_data;
  logic        bc_valid;
  logic        bc_ready;
  logic        bc_inv;
  logic        done;
  logic        busy;
`ifdef MAT_BC_TX_PARITY_EN
  logic        bc_parity;
`endif

  // Reference model: a busy flag, the command length, accepted/sent element counts and the FIFO contents.
  bit          mBusy;
  int          mLen;
  int          mIn;
  int          mOut;
  logic [63:0] mQ[$];
  logic [63:0] opsQ[$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mat_bc_tx #(.NrLanes(4), .Depth(DEPTH)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .cmd_valid_i         (cmd_valid),
    .cmd_ready_o         (cmd_ready),
    .cmd_len_i           (cmd_len),
    .opnd_valid_i        (opnd_valid),
    .opnd_ready_o        (opnd_ready),
    .opnd_data_i         (opnd_data),
    .bc_data_o           (bc_data),
    .bc_data_valid_o     (bc_valid),
    .bc_data_ready_i     (bc_ready),
    .bc_data_invalidate_i(bc_inv),
`ifdef MAT_BC_TX_PARITY_EN
    .bc_parity_o         (bc_parity),
`endif
    .done_o              (done),
    .busy_o              (busy)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mBusy = 1'b0;
    mLen  = 0;
    mIn   = 0;
    mOut  = 0;
    mQ.delete();
  endtask

  // Drives one cycle of inputs, checks outputs on the falling edge, then advances the model past the rising edge.
  task automatic applyStimulus(input bit cv, input logic [15:0] len, input bit ov, input logic [63:0] od,
                               input bit rdy, input bit inv, output bit opAcc);
    bit          expOpRdy;
    bit          expValid;
    bit          expDone;
    logic [63:0] expData;
    cmd_valid  = cv;
    cmd_len    = len;
    opnd_valid = ov;
    opnd_data  = od;
    bc_ready   = rdy;
    bc_inv     = inv;
    @(negedge clk);
    expOpRdy = mBusy && (mQ.size() < DEPTH) && (mIn < mLen);
    expValid = (mQ.size() > 0);
    expData  = expValid ? mQ[0] : 64'd0;
    expDone  = mBusy && (mOut == mLen) && !inv;
    checkOutput("cmd_ready", {63'd0, cmd_ready}, {63'd0, !mBusy});
    checkOutput("busy", {63'd0, busy}, {63'd0, mBusy});
    checkOutput("opnd_ready", {63'd0, opnd_ready}, {63'd0, expOpRdy});
    checkOutput("bc_valid", {63'd0, bc_valid}, {63'd0, expValid});
    checkOutput("bc_data", bc_data, expData);
    checkOutput("done", {63'd0, done}, {63'd0, expDone});
`ifdef MAT_BC_TX_PARITY_EN
    checkOutput("bc_parity", {63'd0, bc_parity}, {63'd0, ^expData});
`endif
    opAcc = 1'b0;
    if (inv) begin
      modelReset();
    end else if (!mBusy) begin
      if (cv) begin
        mBusy = 1'b1;
        mLen  = int'(len);
        mIn   = 0;
        mOut  = 0;
      end
    end else if (expDone) begin
      mBusy = 1'b0;
    end else begin
      if (expValid && rdy) begin
        void'(mQ.pop_front());
        mOut++;
      end
      if (ov && expOpRdy) begin
        mQ.push_back(od);
        mIn++;
        opAcc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issueCmd(input logic [15:0] len);
    bit acc;
    applyStimulus(1'b1, len, 1'b0, 64'd0, 1'b1, 1'b0, acc);
  endtask

  // Offers queued operands for a fixed number of cycles, dropping each one the model says was accepted.
  task automatic feedCycles(input int cycles, input bit rdy);
    bit acc;
    for (int k = 0; k < cycles; k++) begin
      applyStimulus(1'b0, 16'd0, opsQ.size() > 0, (opsQ.size() > 0) ? opsQ[0] : 64'd0, rdy, 1'b0, acc);
      if (acc) void'(opsQ.pop_front());
    end
  endtask

  task automatic resetMidCycle();
    cmd_valid  = 1'b0;
    opnd_valid = 1'b0;
    bc_ready   = 1'b0;
    bc_inv     = 1'b0;
    rst_n      = 1'b0;
    #1;
    checkOutput("rst_bc_data", bc_data, 64'd0);
    checkOutput("rst_bc_valid", {63'd0, bc_valid}, 64'd0);
    checkOutput("rst_opnd_ready", {63'd0, opnd_ready}, 64'd0);
    checkOutput("rst_done", {63'd0, done}, 64'd0);
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    modelReset();
    opsQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit acc;
    int guard;
    cmd_valid  = 1'b0;
    cmd_len    = 16'd0;
    opnd_valid = 1'b0;
    opnd_data  = 64'd0;
    bc_ready   = 1'b0;
    bc_inv     = 1'b0;
    modelReset();

    $display("[TB] power-on reset");
    rst_n = 1'b1;
    #1;
    resetMidCycle();

    $display("[TB] len=3 with ready held high");
    issueCmd(16'd3);
    opsQ = '{64'hA, 64'hB, 64'hC};
    feedCycles(8, 1'b1);

    $display("[TB] len=8 with ready low until the FIFO fills");
    issueCmd(16'd8);
    opsQ = '{64'h11, 64'h22, 64'h33, 64'h44, 64'h55, 64'h66, 64'h77, 64'h88};
    feedCycles(8, 1'b0);
    checkOutput("fifo_full_pushes", 64'(mIn), 64'd4);
    feedCycles(16, 1'b1);

    $display("[TB] len=0");
    issueCmd(16'd0);
    feedCycles(3, 1'b1);

    $display("[TB] invalidate after 2 of 5 sent");
    issueCmd(16'd5);
    opsQ = '{64'h101, 64'h102, 64'h103, 64'h104, 64'h105};
    guard = 0;
    while (mOut < 2 && guard < 40) begin
      feedCycles(1, 1'b1);
      guard++;
    end
    checkOutput("inv_sent_before", 64'(mOut), 64'd2);
    applyStimulus(1'b0, 16'd0, 1'b1, 64'h999, 1'b1, 1'b1, acc);
    opsQ.delete();
    feedCycles(2, 1'b1);
    issueCmd(16'd1);
    opsQ = '{64'h5A5A};
    feedCycles(5, 1'b1);

    $display("[TB] reset with three entries buffered");
    issueCmd(16'd6);
    opsQ = '{64'h201, 64'h202, 64'h203, 64'h204, 64'h205, 64'h206};
    guard = 0;
    while (mQ.size() < 3 && guard < 20) begin
      feedCycles(1, 1'b0);
      guard++;
    end
    checkOutput("pre_reset_fill", 64'(mQ.size()), 64'd3);
    resetMidCycle();
    feedCycles(2, 1'b1);

    $display("[TB] parity data 0x7 then 0x3");
    issueCmd(16'd2);
    opsQ = '{64'h7, 64'h3};
    feedCycles(6, 1'b1);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 3) == 0), 16'($urandom_range(0, 9)), ($urandom_range(0, 3) != 0),
                    {$urandom, $urandom}, ($urandom_range(0, 9) < 7), ($urandom_range(0, 59) == 0), acc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
